// File: rtl/reg_wb_queue.sv
// Register-file writeback queue: in-order FIFO that drains one write per cycle to the
// regfile port and flags pending writes. Define REG_WB_BYPASS_EN to add youngest-match forwarding.
module reg_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     rf_stall,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [$clog2(DEPTH):0]   q_level,
  output logic                     q_empty,
  input  logic [ADDR_W-1:0]        chk_addr1,
  input  logic [ADDR_W-1:0]        chk_addr2,
  output logic                     pend1,
  output logic                     pend2,
  output logic                     fwd_valid1,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic                     fwd_valid2,
  output logic [DATA_W-1:0]        fwd_data2
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]  count_reg;
  logic              rf_we_reg;
  logic [ADDR_W-1:0] rf_waddr_reg;
  logic [DATA_W-1:0] rf_wdata_reg;

  logic push, pop;

  assign in_ready = (count_reg != LVL_W'(DEPTH));
  assign push     = in_valid && in_ready;
  // Pop decision uses the pre-edge level, so a push into an empty queue is never popped on the same edge.
  assign pop      = (count_reg != '0) && !rf_stall;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= in_addr;
      data_mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + LVL_W'(1);
        2'b01:   count_reg <= count_reg - LVL_W'(1);
        default: count_reg <= count_reg;
      endcase
      rf_we_reg <= pop;
      if (pop) begin
        rf_waddr_reg <= addr_mem[rd_ptr_reg];
        rf_wdata_reg <= data_mem[rd_ptr_reg];
      end
    end
  end

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;
  assign q_level  = count_reg;
  assign q_empty  = (count_reg == '0);

  // Slot gi is the gi-th oldest live entry; higher gi means younger.
  logic [PTR_W-1:0] slot_idx [DEPTH];
  logic [DEPTH-1:0] hit1, hit2;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic slot_live;
      assign slot_idx[gi] = rd_ptr_reg + PTR_W'(gi);
      assign slot_live    = (LVL_W'(gi) < count_reg);
      assign hit1[gi]     = slot_live && (addr_mem[slot_idx[gi]] == chk_addr1);
      assign hit2[gi]     = slot_live && (addr_mem[slot_idx[gi]] == chk_addr2);
    end
  endgenerate

  assign pend1 = (|hit1) || (rf_we_reg && (rf_waddr_reg == chk_addr1));
  assign pend2 = (|hit2) || (rf_we_reg && (rf_waddr_reg == chk_addr2));

`ifdef REG_WB_BYPASS_EN
  // In-flight stage is the fallback; walking oldest to youngest lets the newest match win.
  always_comb begin
    fwd_data1 = rf_wdata_reg;
    fwd_data2 = rf_wdata_reg;
    for (int k = 0; k < DEPTH; k++) begin
      if (hit1[k]) fwd_data1 = data_mem[slot_idx[k]];
      if (hit2[k]) fwd_data2 = data_mem[slot_idx[k]];
    end
  end
  assign fwd_valid1 = pend1;
  assign fwd_valid2 = pend2;
`else
  assign fwd_valid1 = 1'b0;
  assign fwd_valid2 = 1'b0;
  assign fwd_data1  = '0;
  assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Scoreboard bench for reg_wb_queue: accepted writes are queued in a reference FIFO and
// compared against each regfile write; hazard/forward outputs are checked every cycle.
module tb_reg_wb_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  logic clk, rst_n;
  logic in_valid, in_ready, rf_stall, rf_we;
  logic [ADDR_W-1:0] in_addr, rf_waddr, chk_addr1, chk_addr2;
  logic [DATA_W-1:0] in_data, rf_wdata, fwd_data1, fwd_data2;
  logic [$clog2(DEPTH):0] q_level;
  logic q_empty, pend1, pend2, fwd_valid1, fwd_valid2;

  reg_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .rf_stall(rf_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_level(q_level), .q_empty(q_empty),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .pend1(pend1), .pend2(pend2),
    .fwd_valid1(fwd_valid1), .fwd_data1(fwd_data1),
    .fwd_valid2(fwd_valid2), .fwd_data2(fwd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+DATA_W-1:0] sb_q[$];
  logic              m_we;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_pend(input logic [ADDR_W-1:0] a);
    bit p = m_we && (m_waddr == a);
    foreach (sb_q[i]) if (sb_q[i][ADDR_W+DATA_W-1:DATA_W] == a) p = 1'b1;
    return p;
  endfunction

  function automatic logic [DATA_W-1:0] exp_fwd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d = m_wdata;
    foreach (sb_q[i]) if (sb_q[i][ADDR_W+DATA_W-1:DATA_W] == a) d = sb_q[i][DATA_W-1:0];
    return d;
  endfunction

  task automatic check_hazard();
    check("pend1", pend1, exp_pend(chk_addr1));
    check("pend2", pend2, exp_pend(chk_addr2));
`ifdef REG_WB_BYPASS_EN
    check("fwd_valid1", fwd_valid1, exp_pend(chk_addr1));
    check("fwd_valid2", fwd_valid2, exp_pend(chk_addr2));
    if (exp_pend(chk_addr1)) check("fwd_data1", fwd_data1, exp_fwd(chk_addr1));
    if (exp_pend(chk_addr2)) check("fwd_data2", fwd_data2, exp_fwd(chk_addr2));
`else
    check("fwd_valid1", fwd_valid1, 0);
    check("fwd_valid2", fwd_valid2, 0);
    check("fwd_data1", fwd_data1, 0);
    check("fwd_data2", fwd_data2, 0);
`endif
  endtask

  // One clock: the reference decides accept/pop from pre-edge state, then outputs are compared.
  task automatic tick();
    int pre;
    bit acc, exp_pop;
    logic [ADDR_W+DATA_W-1:0] e;
    pre     = sb_q.size();
    acc     = in_valid && (pre < DEPTH);
    exp_pop = (pre > 0) && !rf_stall;
    @(posedge clk);
    if (acc) sb_q.push_back({in_addr, in_data});
    m_we = exp_pop;
    if (exp_pop) begin
      e = sb_q.pop_front();
      m_waddr = e[ADDR_W+DATA_W-1:DATA_W];
      m_wdata = e[DATA_W-1:0];
    end
    #1;
    check("rf_we", rf_we, m_we);
    check("rf_waddr", rf_waddr, m_waddr);
    check("rf_wdata", rf_wdata, m_wdata);
    check("q_level", q_level, sb_q.size());
    check("q_empty", q_empty, sb_q.size() == 0);
    check("in_ready", in_ready, sb_q.size() < DEPTH);
    check_hazard();
    if (rf_we) $display("write addr=%0d data=%02h level=%0d", rf_waddr, rf_wdata, q_level);
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_valid = 1'b1; in_addr = a; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_we = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    rf_stall = 1'b0; chk_addr1 = '0; chk_addr2 = '0;
    model_reset();
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_q_empty", q_empty, 1);
    check("rst_q_level", q_level, 0);
    @(negedge clk); rst_n = 1'b1;

    // Single write latency
    chk_addr1 = 3; chk_addr2 = 4;
    push(3, 8'hA5);
    tick();
    check("single_we", rf_we, 1);
    check("single_data", rf_wdata, 8'hA5);
    tick();
    check("single_we_drop", rf_we, 0);
    check("single_level", q_level, 0);

    // Fill under stall, overflow push ignored, then ordered drain
    rf_stall = 1'b1;
    for (int i = 0; i < 5; i++) push(3'(i), 8'((i + 1) * 16));
    check("full_level", q_level, 4);
    check("full_ready", in_ready, 0);
    rf_stall = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Two writes to the same register: youngest forwarded
    rf_stall = 1'b1; chk_addr1 = 1; chk_addr2 = 5;
    push(1, 8'h11);
    push(1, 8'h22);
    check("haz_pend1", pend1, 1);
    check("haz_pend2", pend2, 0);
`ifdef REG_WB_BYPASS_EN
    check("haz_fwd1", fwd_data1, 8'h22);
`else
    check("haz_fwd1", fwd_data1, 0);
`endif
    // Level 2, streaming push+pop keeps level constant
    rf_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_addr2 = 3'(i + 2);
      push(3'(i + 2), 8'(8'h60 + i));
      check("stream_level", q_level, 2);
    end
    for (int i = 0; i < 3; i++) tick();

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      rf_stall  = ($urandom_range(0, 3) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_addr   = 3'($urandom_range(0, 7));
      in_data   = 8'($urandom_range(0, 255));
      chk_addr1 = 3'($urandom_range(0, 7));
      chk_addr2 = 3'($urandom_range(0, 7));
      tick();
    end
    in_valid = 1'b0; rf_stall = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Asynchronous reset in the middle of a drain
    rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(3'(7 - i), 8'(8'hC0 + i));
    rf_stall = 1'b0;
    tick();
    check("pre_rst_we", rf_we, 1);
    check("pre_rst_level", q_level, 3);
    #2; rst_n = 1'b0; #1;
    check("async_rf_we", rf_we, 0);
    check("async_q_level", q_level, 0);
    check("async_q_empty", q_empty, 1);
    check("async_in_ready", in_ready, 1);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
